reduce_seq_ctrl: RTL and testbench
==================================

Name: reduce_seq_ctrl

Overview:
- Multi-cycle sequencer around one shared CHUNK-bit reduction unit (AND/OR/XOR tree of the andN kind).
- Folds a WIDTH-bit operand into a 1-bit result, one CHUNK per cycle, LSB chunk first.
- Sits between a requesting block and the narrow reducer: trades area for latency on Cyclone IV designs where a full-width tree is too costly.
- Start/done handshake; result held until the next job is accepted.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits reduced per cycle; 1 <= CHUNK <= WIDTH.
- NCH (localparam), WIDTH/CHUNK, number of chunks per job.
- CW (localparam), $clog2(NCH+1), width of the chunk counter and nchunks output.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- op  input  2  operation, sampled with start: 00 = AND, 01 = OR, 10 = XOR, 11 = reserved (treated as AND).
- din  input  WIDTH  operand, captured into an internal shift register when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; y and nchunks are valid from this cycle on.
- y  output  1  reduction result, held until the next accepted start.
- nchunks  output  CW  number of chunks consumed by the last job.

Behaviour:
- Reset values: state = IDLE, busy = 0, done = 0, y = 0, nchunks = 0, chunk counter = 0, accumulator = 0, shift register = 0.
- Reset has priority over every other event, including mid-RUN. The job is aborted, no done pulse is produced, and outputs return to their reset values.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1, latch din into the shift register and latch op.
  - Initialise the accumulator to 1 for AND, 0 for OR/XOR. Clear the counter. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Reduce the low CHUNK bits of the shift register with the selected op to r.
  - Update acc <= acc op r; shift the register right by CHUNK; increment the counter.
  - Leave for DONE when the counter reaches NCH-1 during this cycle, i.e. after the last chunk is folded.
- DONE, for exactly one cycle:
  - done = 1; y = acc; nchunks = counter value.
  - Unconditionally return to IDLE.
- start:
  - Ignored in RUN and DONE; no queueing.
  - If start is held high, the next job is accepted in the IDLE cycle following DONE.
- Latency: start sampled at edge E0; RUN occupies NCH cycles; done is high in the cycle after the last RUN cycle.
  - Start-to-done is NCH+1 cycles.
  - Job-to-job throughput is NCH+2 cycles.
- Changes on din and op while busy have no effect.
- CHUNK = WIDTH: single RUN cycle; start-to-done = 2 cycles.
- y and nchunks change only in the DONE cycle (or on reset).

Optional Feature:
- Macro: REDUCE_SEQ_EARLY_EXIT_EN.
- When defined:
  - AND: if the updated acc becomes 0, go to DONE after this RUN cycle.
  - OR: if the updated acc becomes 1, go to DONE after this RUN cycle.
  - nchunks reports the chunks actually consumed.
  - XOR never exits early.
- When undefined: every job consumes exactly NCH chunks; nchunks = NCH always.
- y is identical in both builds for all inputs.

Test Plan:
- WIDTH=32, CHUNK=8. din=0xFFFFFFFF, op=AND, 1-cycle start -> busy for 5 cycles, done pulse 5 cycles after start edge, y=1, nchunks=4 (both builds).
- din=0xFFFF7FFF, op=AND -> y=1? no: y=0. nchunks=4 without macro. With REDUCE_SEQ_EARLY_EXIT_EN, nchunks=2 and done 3 cycles after start.
- din=0x00000100, op=OR -> y=1. nchunks=4 without macro, 2 with it. Then din=0x00000000, op=OR -> y=0, nchunks=4.
- din=0x80000001, op=XOR -> y=0, nchunks=4. Then din=0x80000000 -> y=1. op=11 with din=0xFFFFFFFF -> y=1 (AND behaviour).
- Start a job, assert reset in 2nd RUN cycle -> next cycle busy=0, y=0, nchunks=0, no done pulse. A new start afterwards completes normally.
- Hold start=1 continuously with din=0xFFFFFFFF, AND -> done pulses every 6 cycles. din/op toggled while busy are ignored (y stays 1).

Source files
------------

// File: rtl/reduce_seq_ctrl.sv
// Sequencer folding a WIDTH-bit operand to one AND/OR/XOR bit, CHUNK bits per cycle, LSB first.
// Optional macro REDUCE_SEQ_EARLY_EXIT_EN: stop as soon as an AND/OR result is decided.
module reduce_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCH = WIDTH / CHUNK,
  localparam int CW  = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             y,
  output logic [CW-1:0]    nchunks
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   sh;
  logic [1:0]         opq;
  logic               acc;
  logic [CW-1:0]      cnt;

  logic [CHUNK-1:0]   chunk;
  logic               r;
  logic               acc_nxt;
  logic [CW-1:0]      cnt_nxt;
  logic               last;
  logic               finish;

  // Shared narrow reducer; op 11 falls through to AND.
  always_comb begin
    chunk   = sh[CHUNK-1:0];
    r       = &chunk;
    acc_nxt = acc & r;
    case (opq)
      2'b01: begin
        r       = |chunk;
        acc_nxt = acc | r;
      end
      2'b10: begin
        r       = ^chunk;
        acc_nxt = acc ^ r;
      end
      default: begin
        r       = &chunk;
        acc_nxt = acc & r;
      end
    endcase
  end

  assign cnt_nxt = cnt + CW'(1);
  assign last    = (cnt == CW'(NCH - 1));

`ifdef REDUCE_SEQ_EARLY_EXIT_EN
  // A zero under AND or a one under OR already fixes the result.
  assign finish = last
                || (((opq == 2'b00) || (opq == 2'b11)) && !acc_nxt)
                || ((opq == 2'b01) && acc_nxt);
`else
  assign finish = last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      opq     <= 2'b00;
      acc     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= 1'b0;
      nchunks <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh    <= din;
            opq   <= op;
            acc   <= ((op == 2'b01) || (op == 2'b10)) ? 1'b0 : 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          sh  <= sh >> CHUNK;
          cnt <= cnt_nxt;
          if (finish) begin
            // Outputs registered here so they appear together with the done pulse.
            done    <= 1'b1;
            y       <= acc_nxt;
            nchunks <= cnt_nxt;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_seq_ctrl.sv
// Self-checking bench for reduce_seq_ctrl against a whole-word reduction model.
// Honours REDUCE_SEQ_EARLY_EXIT_EN for the expected chunk count and latency.
module tb_reduce_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CW    = $clog2(NCH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             y;
  logic [CW-1:0]    nchunks;

  int checks = 0;
  int errors = 0;

  reduce_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .din(din),
    .busy(busy), .done(done), .y(y), .nchunks(nchunks)
  );

  always #5 clk = ~clk;

  function automatic logic model_y(input logic [WIDTH-1:0] d, input logic [1:0] o);
    case (o)
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return &d;
    endcase
  endfunction

  function automatic int model_n(input logic [WIDTH-1:0] d, input logic [1:0] o);
`ifdef REDUCE_SEQ_EARLY_EXIT_EN
    logic [CHUNK-1:0] c;
    for (int k = 0; k < NCH; k++) begin
      c = d[k*CHUNK +: CHUNK];
      if (o == 2'b01 && c != '0) return k + 1;
      if ((o == 2'b00 || o == 2'b11) && c != '1) return k + 1;
    end
    return NCH;
`else
    return NCH;
`endif
  endfunction

  // Drives one single-cycle start and measures the job; scrambles din/op while busy.
  task automatic run_job(input logic [WIDTH-1:0] d, input logic [1:0] o,
                         output int lat, output logic yv, output logic [CW-1:0] nv,
                         output int bcnt, output bit hold_ok, output bit idle_ok);
    logic          y0;
    logic [CW-1:0] n0;
    y0 = y; n0 = nchunks;
    lat = 0; bcnt = 0; hold_ok = 1'b1; yv = 1'b0; nv = '0;
    @(negedge clk);
    start = 1'b1; din = d; op = o;
    @(posedge clk); #1;
    start = 1'b0; din = $urandom; op = 2'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i; yv = y; nv = nchunks;
        break;
      end
      if (y !== y0 || nchunks !== n0) hold_ok = 1'b0;
      @(posedge clk); #1;
      din = $urandom; op = 2'($urandom);
    end
    @(posedge clk); #1;
    idle_ok = (busy === 1'b0 && done === 1'b0 && y === yv && nchunks === nv);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 1'b0 || nchunks !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b y=%b nchunks=%0d, required all 0", busy, done, y, nchunks);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] dv [8] = '{32'hFFFFFFFF, 32'hFFFF7FFF, 32'h00000100, 32'h00000000,
                                 32'h80000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [1:0]       ov [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic             ey [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bcnt, en;
    logic yv;
    logic [CW-1:0] nv;
    bit hold_ok, idle_ok;
    for (int i = 0; i < 8; i++) begin
      run_job(dv[i], ov[i], lat, yv, nv, bcnt, hold_ok, idle_ok);
      en = model_n(dv[i], ov[i]);
      checks++;
      if (yv !== ey[i]) begin
        errors++;
        $display("FAIL dir_y[%0d]: got %b, required %b", i, yv, ey[i]);
      end
      checks++;
      if (nv !== CW'(en)) begin
        errors++;
        $display("FAIL dir_nchunks[%0d]: got %0d, required %0d", i, nv, en);
      end
      checks++;
      if (lat != en + 1 || bcnt != en + 1) begin
        errors++;
        $display("FAIL dir_latency[%0d]: done at %0d busy %0d, required %0d", i, lat, bcnt, en + 1);
      end
      checks++;
      if (!hold_ok || !idle_ok) begin
        errors++;
        $display("FAIL dir_hold[%0d]: hold=%0d idle=%0d, required 1 1", i, hold_ok, idle_ok);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [1:0] o;
    int lat, bcnt, en;
    logic yv;
    logic [CW-1:0] nv;
    bit hold_ok, idle_ok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: begin
          d = '1;
          if ($urandom_range(0, 1) == 1) d[$urandom_range(0, WIDTH-1)] = 1'b0;
        end
        default: begin
          d = '0;
          if ($urandom_range(0, 1) == 1) d[$urandom_range(0, WIDTH-1)] = 1'b1;
        end
      endcase
      run_job(d, o, lat, yv, nv, bcnt, hold_ok, idle_ok);
      en = model_n(d, o);
      checks++;
      if (yv !== model_y(d, o) || nv !== CW'(en) || lat != en + 1 || bcnt != en + 1
          || !hold_ok || !idle_ok) begin
        errors++;
        $display("FAIL rand[%0d] d=%h op=%0d: y=%b n=%0d lat=%0d busy=%0d hold=%0d idle=%0d, required y=%b n=%0d lat=%0d",
                 i, d, o, yv, nv, lat, bcnt, hold_ok, idle_ok, model_y(d, o), en, en + 1);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt;
    logic yv;
    logic [CW-1:0] nv;
    bit hold_ok, idle_ok, seen;
    run_job('1, 2'b00, lat, yv, nv, bcnt, hold_ok, idle_ok);
    @(negedge clk);
    start = 1'b1; din = '1; op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 1'b0 || nchunks !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b y=%b nchunks=%0d, required all 0", busy, done, y, nchunks);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_quiet: activity seen=%0d, required 0", seen);
    end
    run_job(32'h80000000, 2'b10, lat, yv, nv, bcnt, hold_ok, idle_ok);
    checks++;
    if (yv !== 1'b1 || nv !== CW'(NCH) || lat != NCH + 1) begin
      errors++;
      $display("FAIL post_reset_job: y=%b n=%0d lat=%0d, required 1 %0d %0d", yv, nv, lat, NCH, NCH + 1);
    end
  endtask

  task automatic test_back_to_back();
    int last_done = -1;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; din = '1; op = 2'b00;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        checks++;
        if (y !== 1'b1) begin
          errors++;
          $display("FAIL b2b_y at cycle %0d: got %b, required 1", cyc, y);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != NCH + 2) begin
            errors++;
            $display("FAIL b2b_period: got %0d, required %0d", cyc - last_done, NCH + 2);
          end
        end
        last_done = cyc;
        ndone++;
      end
      if (busy) begin
        din = $urandom; op = 2'($urandom);
      end else begin
        din = '1; op = 2'b00;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, required 5", ndone);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
